// File: rtl/mem_dev_router.sv
// mem_dev_router: routes one MEM-stage load/store at a time to either the
// CLINT register port or the external data bus, then returns a one-cycle
// completion with registered read data and response code to the LSU.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | ready for a new LSU request; decode on acceptance
// S_CLINT_ACC | CLINT request held until clint_ready_i
// S_BUS_REQ   | bus request held until bus_ready_i or timeout
// S_BUS_WAIT  | request accepted by bus, waiting for bus_rvalid_i
// S_DONE      | one-cycle completion pulse to the LSU
module mem_dev_router #(
    parameter int                ADDR_W      = 64,
    parameter logic [ADDR_W-1:0] CLINT_BASE  = 64'h0000_0000_0200_0000,
    parameter logic [ADDR_W-1:0] CLINT_SIZE  = 64'h1_0000,
    parameter int                BUS_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              lsu_valid_i,
    input  logic              lsu_req_i,
    input  logic [ADDR_W-1:0] lsu_addr_i,
    input  logic [1:0]        lsu_size_i,
    input  logic [63:0]       lsu_data_write_i,
    output logic              lsu_ready_o,
    output logic              lsu_done_o,
    output logic [63:0]       lsu_data_read_o,
    output logic [1:0]        lsu_resp_o,

    output logic              clint_valid_o,
    output logic              clint_req_o,
    output logic [ADDR_W-1:0] clint_addr_o,
    output logic [1:0]        clint_size_o,
    output logic [63:0]       clint_data_write_o,
    input  logic              clint_ready_i,
    input  logic [63:0]       clint_data_read_i,
    input  logic [1:0]        clint_resp_i,

    output logic              bus_valid_o,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [1:0]        bus_size_o,
    output logic [63:0]       bus_data_write_o,
    input  logic              bus_ready_i,
    input  logic              bus_rvalid_i,
    input  logic [63:0]       bus_data_read_i,
    input  logic [1:0]        bus_resp_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLINT_ACC,
        S_BUS_REQ,
        S_BUS_WAIT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_CLINT_MASK = ~(CLINT_SIZE - 1'b1);
    localparam logic [9:0]        LP_TIMEOUT    = 10'(BUS_TIMEOUT);
    localparam logic [1:0]        LP_RESP_OK    = 2'd0;
    localparam logic [1:0]        LP_RESP_MISAL = 2'd2;
    localparam logic [1:0]        LP_RESP_TMO   = 2'd3;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_req;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_size;
    logic [63:0]         r_wdata;
    logic [63:0]         r_rdata;
    logic [1:0]          r_resp;
    logic [9:0]          r_cnt;

    logic                w_misal;
    logic                w_is_clint;
    logic [9:0]          w_cnt_inc;
    logic                w_cap;
    logic [63:0]         w_cap_data;
    logic [1:0]          w_cap_resp;

    // Alignment check on the incoming address; byte accesses never fault.
    always_comb begin
        w_misal = 1'b0;
        case (lsu_size_i)
            2'd1:    w_misal = (lsu_addr_i[0]   != 1'b0);
            2'd2:    w_misal = (lsu_addr_i[1:0] != 2'b00);
            2'd3:    w_misal = (lsu_addr_i[2:0] != 3'b000);
            default: w_misal = 1'b0;
        endcase
    end

    assign w_is_clint = ((lsu_addr_i & LP_CLINT_MASK) == CLINT_BASE);
    assign w_cnt_inc  = r_cnt + 10'd1;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the response capture selected on the way to S_DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_cap_data  = '0;
        w_cap_resp  = LP_RESP_OK;
        case (r_state)
            S_IDLE: begin
                if (lsu_valid_i) begin
                    if (w_misal) begin
                        w_state_nxt = S_DONE;
                        w_cap       = 1'b1;
                        w_cap_resp  = LP_RESP_MISAL;
                    end else if (w_is_clint) begin
                        w_state_nxt = S_CLINT_ACC;
                    end else begin
                        w_state_nxt = S_BUS_REQ;
                    end
                end
            end
            S_CLINT_ACC: begin
                if (clint_ready_i) begin
                    w_state_nxt = S_DONE;
                    w_cap       = 1'b1;
                    w_cap_data  = r_req ? 64'd0 : clint_data_read_i;
                    w_cap_resp  = clint_resp_i;
                end
            end
            S_BUS_REQ: begin
                if (bus_ready_i) begin
                    // A completion arriving with the accept skips S_BUS_WAIT.
                    if (bus_rvalid_i) begin
                        w_state_nxt = S_DONE;
                        w_cap       = 1'b1;
                        w_cap_data  = r_req ? 64'd0 : bus_data_read_i;
                        w_cap_resp  = bus_resp_i;
                    end else begin
                        w_state_nxt = S_BUS_WAIT;
                    end
                end else if (w_cnt_inc == LP_TIMEOUT) begin
                    w_state_nxt = S_DONE;
                    w_cap       = 1'b1;
                    w_cap_resp  = LP_RESP_TMO;
                end
            end
            S_BUS_WAIT: begin
                if (bus_rvalid_i) begin
                    w_state_nxt = S_DONE;
                    w_cap       = 1'b1;
                    w_cap_data  = r_req ? 64'd0 : bus_data_read_i;
                    w_cap_resp  = bus_resp_i;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latched request, bus timeout counter and captured response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_size  <= 2'd0;
            r_wdata <= 64'd0;
            r_rdata <= 64'd0;
            r_resp  <= 2'd0;
            r_cnt   <= 10'd0;
        end else begin
            if (r_state == S_IDLE && lsu_valid_i) begin
                r_req   <= lsu_req_i;
                r_addr  <= lsu_addr_i;
                r_size  <= lsu_size_i;
                r_wdata <= lsu_data_write_i;
                r_cnt   <= 10'd0;
            end
            if (r_state == S_BUS_REQ) begin
                r_cnt <= bus_ready_i ? 10'd0 : w_cnt_inc;
            end
            if (w_cap) begin
                r_rdata <= w_cap_data;
                r_resp  <= w_cap_resp;
            end
        end
    end

    // Ready is masked during reset so every output reads 0 while rst is low.
    assign lsu_ready_o     = (r_state == S_IDLE) && rst;
    assign lsu_done_o      = (r_state == S_DONE);
    assign lsu_data_read_o = r_rdata;
    assign lsu_resp_o      = r_resp;

    assign clint_valid_o      = (r_state == S_CLINT_ACC);
    assign clint_req_o        = clint_valid_o & r_req;
    assign clint_addr_o       = clint_valid_o ? r_addr  : '0;
    assign clint_size_o       = clint_valid_o ? r_size  : 2'd0;
    assign clint_data_write_o = clint_valid_o ? r_wdata : 64'd0;

    assign bus_valid_o      = (r_state == S_BUS_REQ);
    assign bus_req_o        = bus_valid_o & r_req;
    assign bus_addr_o       = bus_valid_o ? r_addr  : '0;
    assign bus_size_o       = bus_valid_o ? r_size  : 2'd0;
    assign bus_data_write_o = bus_valid_o ? r_wdata : 64'd0;

endmodule

// File: tb/tb_mem_dev_router.sv
// Directed bench for mem_dev_router: CLINT path, bus path, misalignment,
// bus timeout, reset abort and back-to-back acceptance.
module tb_mem_dev_router;

    logic        clk;
    logic        rst;
    logic        lsu_valid_i;
    logic        lsu_req_i;
    logic [63:0] lsu_addr_i;
    logic [1:0]  lsu_size_i;
    logic [63:0] lsu_data_write_i;
    logic        lsu_ready_o;
    logic        lsu_done_o;
    logic [63:0] lsu_data_read_o;
    logic [1:0]  lsu_resp_o;
    logic        clint_valid_o;
    logic        clint_req_o;
    logic [63:0] clint_addr_o;
    logic [1:0]  clint_size_o;
    logic [63:0] clint_data_write_o;
    logic        clint_ready_i;
    logic [63:0] clint_data_read_i;
    logic [1:0]  clint_resp_i;
    logic        bus_valid_o;
    logic        bus_req_o;
    logic [63:0] bus_addr_o;
    logic [1:0]  bus_size_o;
    logic [63:0] bus_data_write_o;
    logic        bus_ready_i;
    logic        bus_rvalid_i;
    logic [63:0] bus_data_read_i;
    logic [1:0]  bus_resp_i;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc;

    mem_dev_router dut (
        .clk                (clk),
        .rst                (rst),
        .lsu_valid_i        (lsu_valid_i),
        .lsu_req_i          (lsu_req_i),
        .lsu_addr_i         (lsu_addr_i),
        .lsu_size_i         (lsu_size_i),
        .lsu_data_write_i   (lsu_data_write_i),
        .lsu_ready_o        (lsu_ready_o),
        .lsu_done_o         (lsu_done_o),
        .lsu_data_read_o    (lsu_data_read_o),
        .lsu_resp_o         (lsu_resp_o),
        .clint_valid_o      (clint_valid_o),
        .clint_req_o        (clint_req_o),
        .clint_addr_o       (clint_addr_o),
        .clint_size_o       (clint_size_o),
        .clint_data_write_o (clint_data_write_o),
        .clint_ready_i      (clint_ready_i),
        .clint_data_read_i  (clint_data_read_i),
        .clint_resp_i       (clint_resp_i),
        .bus_valid_o        (bus_valid_o),
        .bus_req_o          (bus_req_o),
        .bus_addr_o         (bus_addr_o),
        .bus_size_o         (bus_size_o),
        .bus_data_write_o   (bus_data_write_o),
        .bus_ready_i        (bus_ready_i),
        .bus_rvalid_i       (bus_rvalid_i),
        .bus_data_read_i    (bus_data_read_i),
        .bus_resp_i         (bus_resp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are settled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        logic [63:0] w_or;
        w_or = {63'd0, lsu_ready_o} | {63'd0, lsu_done_o} | lsu_data_read_o |
               {62'd0, lsu_resp_o} | {63'd0, clint_valid_o} | {63'd0, clint_req_o} |
               clint_addr_o | {62'd0, clint_size_o} | clint_data_write_o |
               {63'd0, bus_valid_o} | {63'd0, bus_req_o} | bus_addr_o |
               {62'd0, bus_size_o} | bus_data_write_o;
        check(tag, w_or, 64'd0);
    endtask

    task automatic lsu_drive(input logic v, input logic req, input logic [63:0] addr,
                             input logic [1:0] size, input logic [63:0] wd);
        lsu_valid_i      = v;
        lsu_req_i        = req;
        lsu_addr_i       = addr;
        lsu_size_i       = size;
        lsu_data_write_i = wd;
    endtask

    initial begin
        rst = 1'b0;
        lsu_drive(1'b0, 1'b0, 64'd0, 2'd0, 64'd0);
        clint_ready_i = 1'b0; clint_data_read_i = 64'd0; clint_resp_i = 2'd0;
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0; bus_data_read_i = 64'd0; bus_resp_i = 2'd0;

        // Reset: every output low.
        tick(); tick();
        check_all_zero("reset_outputs");
        #2 rst = 1'b1;
        tick();
        check("idle_ready", {63'd0, lsu_ready_o}, 64'd1);

        // CLINT read, target ready immediately.
        lsu_drive(1'b1, 1'b0, 64'h0200_BFF8, 2'd3, 64'd0);
        clint_ready_i = 1'b1; clint_data_read_i = 64'h1234; clint_resp_i = 2'd0;
        tick();
        lsu_valid_i = 1'b0;
        check("clint_valid_t1", {63'd0, clint_valid_o}, 64'd1);
        check("clint_addr_t1", clint_addr_o, 64'h0200_BFF8);
        check("clint_size_t1", {62'd0, clint_size_o}, 64'd3);
        check("clint_bus_valid_t1", {63'd0, bus_valid_o}, 64'd0);
        check("clint_ready_low_t1", {63'd0, lsu_ready_o}, 64'd0);
        check("clint_done_t1", {63'd0, lsu_done_o}, 64'd0);
        tick();
        check("clint_done_t2", {63'd0, lsu_done_o}, 64'd1);
        check("clint_rdata", lsu_data_read_o, 64'h1234);
        check("clint_resp", {62'd0, lsu_resp_o}, 64'd0);
        check("clint_valid_t2", {63'd0, clint_valid_o}, 64'd0);
        check("clint_bus_valid_t2", {63'd0, bus_valid_o}, 64'd0);
        tick();
        check("clint_done_t3", {63'd0, lsu_done_o}, 64'd0);
        check("clint_rdata_hold", lsu_data_read_o, 64'h1234);
        clint_ready_i = 1'b0;

        // Bus write: ready in the 4th request cycle, rvalid two cycles later.
        lsu_drive(1'b1, 1'b1, 64'h8000_0000, 2'd2, 64'hDEAD);
        tick();
        lsu_valid_i = 1'b0;
        check("bw_valid_c1", {63'd0, bus_valid_o}, 64'd1);
        check("bw_addr_c1", bus_addr_o, 64'h8000_0000);
        check("bw_req_c1", {63'd0, bus_req_o}, 64'd1);
        check("bw_wdata_c1", bus_data_write_o, 64'hDEAD);
        check("bw_size_c1", {62'd0, bus_size_o}, 64'd2);
        check("bw_clint_c1", {63'd0, clint_valid_o}, 64'd0);
        tick();
        check("bw_valid_c2", {63'd0, bus_valid_o}, 64'd1);
        tick();
        check("bw_valid_c3", {63'd0, bus_valid_o}, 64'd1);
        tick();
        check("bw_valid_c4", {63'd0, bus_valid_o}, 64'd1);
        bus_ready_i = 1'b1;
        tick();
        bus_ready_i = 1'b0;
        check("bw_valid_c5", {63'd0, bus_valid_o}, 64'd0);
        check("bw_addr_c5", bus_addr_o, 64'd0);
        check("bw_done_c5", {63'd0, lsu_done_o}, 64'd0);
        tick();
        bus_rvalid_i = 1'b1; bus_data_read_i = 64'hFFFF; bus_resp_i = 2'd0;
        tick();
        bus_rvalid_i = 1'b0;
        check("bw_done", {63'd0, lsu_done_o}, 64'd1);
        check("bw_rdata_zero", lsu_data_read_o, 64'd0);
        check("bw_resp", {62'd0, lsu_resp_o}, 64'd0);
        tick();
        check("bw_done_once", {63'd0, lsu_done_o}, 64'd0);

        // Misaligned dword read: done next cycle, no target driven.
        lsu_drive(1'b1, 1'b0, 64'h8000_0004, 2'd3, 64'd0);
        tick();
        lsu_valid_i = 1'b0;
        check("mis_done", {63'd0, lsu_done_o}, 64'd1);
        check("mis_resp", {62'd0, lsu_resp_o}, 64'd2);
        check("mis_rdata", lsu_data_read_o, 64'd0);
        check("mis_no_target", {62'd0, bus_valid_o, clint_valid_o}, 64'd0);
        tick();
        check("mis_done_once", {63'd0, lsu_done_o}, 64'd0);
        check("mis_no_target2", {62'd0, bus_valid_o, clint_valid_o}, 64'd0);

        // Bus timeout: valid held for exactly 1023 cycles.
        lsu_drive(1'b1, 1'b0, 64'h8000_0008, 2'd3, 64'd0);
        tick();
        lsu_valid_i = 1'b0;
        n_cyc = 0;
        while (bus_valid_o === 1'b1 && n_cyc < 2000) begin
            n_cyc++;
            tick();
        end
        check("tmo_valid_cycles", 64'(n_cyc), 64'd1023);
        check("tmo_done", {63'd0, lsu_done_o}, 64'd1);
        check("tmo_resp", {62'd0, lsu_resp_o}, 64'd3);
        check("tmo_rdata", lsu_data_read_o, 64'd0);
        tick();

        // Next request: bus read with ready and rvalid together, resp forwarded.
        lsu_drive(1'b1, 1'b0, 64'h8000_0010, 2'd3, 64'd0);
        bus_ready_i = 1'b1; bus_rvalid_i = 1'b1;
        bus_data_read_i = 64'hCAFE_0000_1111; bus_resp_i = 2'd1;
        check("after_tmo_ready", {63'd0, lsu_ready_o}, 64'd1);
        tick();
        lsu_valid_i = 1'b0;
        check("br_valid", {63'd0, bus_valid_o}, 64'd1);
        tick();
        bus_ready_i = 1'b0; bus_rvalid_i = 1'b0;
        check("br_done", {63'd0, lsu_done_o}, 64'd1);
        check("br_rdata", lsu_data_read_o, 64'hCAFE_0000_1111);
        check("br_resp", {62'd0, lsu_resp_o}, 64'd1);
        tick();

        // Reset while waiting for the bus completion.
        lsu_drive(1'b1, 1'b0, 64'h8000_0020, 2'd3, 64'd0);
        bus_ready_i = 1'b1;
        tick();
        lsu_valid_i = 1'b0;
        tick();
        bus_ready_i = 1'b0;
        check("rw_in_wait", {63'd0, bus_valid_o}, 64'd0);
        #2 rst = 1'b0;
        #1;
        check_all_zero("rw_reset_outputs");
        #1 rst = 1'b1;
        bus_rvalid_i = 1'b1; bus_data_read_i = 64'hBAD0; bus_resp_i = 2'd1;
        lsu_drive(1'b1, 1'b0, 64'h0200_0000, 2'd2, 64'd0);
        clint_ready_i = 1'b1; clint_data_read_i = 64'h55AA; clint_resp_i = 2'd0;
        #1;
        check("rw_ready_after", {63'd0, lsu_ready_o}, 64'd1);
        check("rw_no_done", {63'd0, lsu_done_o}, 64'd0);
        tick();
        lsu_valid_i = 1'b0;
        check("rw_clint_valid", {63'd0, clint_valid_o}, 64'd1);
        check("rw_bus_quiet", {63'd0, bus_valid_o}, 64'd0);
        tick();
        bus_rvalid_i = 1'b0;
        check("rw_done", {63'd0, lsu_done_o}, 64'd1);
        check("rw_rdata", lsu_data_read_o, 64'h55AA);
        check("rw_resp", {62'd0, lsu_resp_o}, 64'd0);
        tick();
        check("rw_done_once", {63'd0, lsu_done_o}, 64'd0);

        // Back-to-back CLINT reads with lsu_valid_i held high.
        lsu_drive(1'b1, 1'b0, 64'h0200_4000, 2'd3, 64'd0);
        clint_data_read_i = 64'h1111;
        check("b2b_ready_a", {63'd0, lsu_ready_o}, 64'd1);
        tick();
        check("b2b_busy_a", {63'd0, lsu_ready_o}, 64'd0);
        check("b2b_valid_a", {63'd0, clint_valid_o}, 64'd1);
        tick();
        lsu_addr_i = 64'h0200_4008;
        clint_data_read_i = 64'h2222;
        check("b2b_done_a", {63'd0, lsu_done_o}, 64'd1);
        check("b2b_ready_in_done", {63'd0, lsu_ready_o}, 64'd0);
        check("b2b_rdata_a", lsu_data_read_o, 64'h1111);
        tick();
        check("b2b_ready_b", {63'd0, lsu_ready_o}, 64'd1);
        check("b2b_idle_no_valid", {63'd0, clint_valid_o}, 64'd0);
        check("b2b_done_gap", {63'd0, lsu_done_o}, 64'd0);
        tick();
        lsu_valid_i = 1'b0;
        check("b2b_valid_b", {63'd0, clint_valid_o}, 64'd1);
        check("b2b_addr_b", clint_addr_o, 64'h0200_4008);
        tick();
        check("b2b_done_b", {63'd0, lsu_done_o}, 64'd1);
        check("b2b_rdata_b", lsu_data_read_o, 64'h2222);
        clint_ready_i = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
